// File: rtl/ldvio_valid_writer.sv
// Write-side controller for the load-violation valid RAM: buffers LSU set/clear
// requests in a small FIFO and drives the single RAM write port, with full sweeps.
module ldvio_valid_writer #(
   parameter int DEPTH        = 16,
   parameter int INDEX        = 4,
   parameter int WIDTH        = 1,
   parameter int FIFO_DEPTH   = 4,
   parameter int CLEAR_PERIOD = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             viol_valid_i,
   input  logic [INDEX-1:0] viol_idx_i,
   input  logic [WIDTH-1:0] viol_data_i,
   output logic             viol_ready_o,
   input  logic             clear_req_i,
   output logic [INDEX-1:0] addr0wr_o,
   output logic [WIDTH-1:0] data0wr_o,
   output logic             we0_o,
   output logic             busy_o
);
   localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int PW  = FAW + 1;
   localparam int PCW = (CLEAR_PERIOD > 0) ? $clog2(CLEAR_PERIOD + 1) : 1;
   localparam logic [PCW-1:0]   PER_LAST = (CLEAR_PERIOD > 0) ? PCW'(CLEAR_PERIOD - 1) : '0;
   localparam logic [INDEX-1:0] IDX_LAST = INDEX'(DEPTH - 1);

   typedef struct packed {
      logic [INDEX-1:0] idx;
      logic [WIDTH-1:0] data;
   } req_t;

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t           state_q;
   req_t             fifo_q [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [INDEX-1:0] sweep_idx_q;
   logic [PCW-1:0]   per_q;

   logic fifo_empty, fifo_full, push, pop, period_hit, start;
   req_t head, in_req;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                       (wr_ptr_q[FAW-1:0] == rd_ptr_q[FAW-1:0]);
   assign viol_ready_o = !fifo_full;

   assign push       = viol_valid_i && !fifo_full;
   assign pop        = (state_q == IDLE) && !fifo_empty;
   assign period_hit = (CLEAR_PERIOD != 0) && (per_q == PER_LAST);
   assign start      = clear_req_i || ((state_q == IDLE) && period_hit);
   assign head       = fifo_q[rd_ptr_q[FAW-1:0]];
   assign in_req     = '{idx: viol_idx_i, data: viol_data_i};

   // Flush moves the read pointer onto the pre-push write pointer, so a request
   // accepted on the sweep-start edge survives as the only entry.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (start)    rd_ptr_d = wr_ptr_q;
      else if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q[FAW-1:0]] <= in_req;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         sweep_idx_q <= '0;
         per_q       <= '0;
         addr0wr_o   <= '0;
         data0wr_o   <= '0;
         we0_o       <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         case (state_q)
            IDLE: begin
               we0_o  <= pop;
               busy_o <= 1'b0;
               if (pop) begin
                  addr0wr_o <= head.idx;
                  data0wr_o <= head.data;
               end
               if (start) begin
                  state_q     <= SWEEP;
                  sweep_idx_q <= '0;
                  per_q       <= '0;
               end else if (CLEAR_PERIOD != 0) begin
                  per_q <= per_q + PCW'(1);
               end
            end
            SWEEP: begin
               addr0wr_o <= sweep_idx_q;
               data0wr_o <= '0;
               we0_o     <= 1'b1;
               busy_o    <= 1'b1;
               per_q     <= '0;
               if (clear_req_i) begin
                  sweep_idx_q <= '0;
               end else if (sweep_idx_q == IDX_LAST) begin
                  state_q     <= IDLE;
                  sweep_idx_q <= '0;
               end else begin
                  sweep_idx_q <= sweep_idx_q + INDEX'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ldvio_valid_writer.sv
// Directed bench for ldvio_valid_writer; a second instance with CLEAR_PERIOD=8
// covers periodic sweeps.
module tb_ldvio_valid_writer;
   logic       clk = 1'b0, reset = 1'b1, viol_valid = 1'b0, clear_req = 1'b0;
   logic [3:0] viol_idx = '0;
   logic [0:0] viol_data = '0;
   logic       ready, we, busy, ready_p, we_p, busy_p;
   logic [3:0] addr, addr_p;
   logic [0:0] data, data_p;
   int         total = 0, bad = 0;
   logic       cap_en = 1'b0;
   logic [5:0] cap_q [$];   // {busy, addr, data} of each write seen on the main DUT

   always #5 clk = ~clk;

   ldvio_valid_writer #(.CLEAR_PERIOD(1024)) dut (
      .clk(clk), .reset(reset), .viol_valid_i(viol_valid), .viol_idx_i(viol_idx),
      .viol_data_i(viol_data), .viol_ready_o(ready), .clear_req_i(clear_req),
      .addr0wr_o(addr), .data0wr_o(data), .we0_o(we), .busy_o(busy));

   ldvio_valid_writer #(.CLEAR_PERIOD(8)) dut_p (
      .clk(clk), .reset(reset), .viol_valid_i(viol_valid), .viol_idx_i(viol_idx),
      .viol_data_i(viol_data), .viol_ready_o(ready_p), .clear_req_i(clear_req),
      .addr0wr_o(addr_p), .data0wr_o(data_p), .we0_o(we_p), .busy_o(busy_p));

   always @(negedge clk) if (cap_en && we) cap_q.push_back({busy, addr, data});

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; viol_valid = 1'b0; clear_req = 1'b0;
      step(); step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      // dirty the block: start a sweep and buffer requests, then reset mid-sweep
      reset = 1'b0; viol_valid = 1'b1; viol_idx = 4'd9; viol_data = 1'b1; clear_req = 1'b1;
      step(); clear_req = 1'b0; step();
      reset = 1'b1; viol_valid = 1'b0;
      step(); step();
      total++; if (we !== 1'b0)       begin bad++; $display("FAIL rst_we: got %b want 0", we); end
      total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      total++; if (addr !== 4'd0)     begin bad++; $display("FAIL rst_addr: got %0d want 0", addr); end
      total++; if (data !== 1'b0)     begin bad++; $display("FAIL rst_data: got %b want 0", data); end
      total++; if (ready !== 1'b1)    begin bad++; $display("FAIL rst_ready: got %b want 1", ready); end
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         total++; if (we !== 1'b0) begin bad++; $display("FAIL rst_lost_req c=%0d: we=%b want 0", c, we); end
      end
   endtask

   task automatic test_single_write();
      do_reset();
      viol_valid = 1'b1; viol_idx = 4'd5; viol_data = 1'b1;
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", ready); end
      step(); viol_valid = 1'b0;
      total++; if (we !== 1'b0) begin bad++; $display("FAIL single_e0_we: got %b want 0", we); end
      step();
      total++; if ({we, addr, data} !== {1'b1, 4'd5, 1'b1}) begin
         bad++; $display("FAIL single_write: got we=%b addr=%0d data=%b want 1/5/1", we, addr, data); end
      step();
      total++; if (we !== 1'b0) begin bad++; $display("FAIL single_after_we: got %b want 0", we); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] ix [6];
      logic       dv [6];
      ix = '{4'd3, 4'd7, 4'd3, 4'd12, 4'd0, 4'd15};
      dv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      do_reset(); cap_q.delete(); cap_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         viol_valid = 1'b1; viol_idx = ix[i]; viol_data = dv[i];
         total++; if (ready !== 1'b1) begin bad++; $display("FAIL b2b_ready i=%0d: got %b want 1", i, ready); end
         step();
      end
      viol_valid = 1'b0; repeat (3) step(); cap_en = 1'b0;
      total++; if (cap_q.size() != 6) begin bad++; $display("FAIL b2b_count: got %0d want 6", cap_q.size()); end
      for (int i = 0; i < 6 && i < cap_q.size(); i++) begin
         total++; if (cap_q[i] !== {1'b0, ix[i], dv[i]}) begin
            bad++; $display("FAIL b2b_write i=%0d: got %h want %h", i, cap_q[i], {1'b0, ix[i], dv[i]}); end
      end
   endtask

   task automatic test_backpressure();
      logic [5:0] exp_q [$];
      int n;
      do_reset(); clear_req = 1'b1; step(); clear_req = 1'b0;
      cap_q.delete(); cap_en = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         viol_valid = 1'b1; viol_idx = 4'(k); viol_data = 1'b1; step();
      end
      viol_idx = 4'd5;
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low: got %b want 0", ready); end
      n = 0;
      while (ready !== 1'b1 && n < 40) begin step(); n++; end
      total++; if (n >= 40) begin bad++; $display("FAIL bp_ready_timeout: ready=%b after %0d cycles want 1", ready, n); end
      step(); viol_valid = 1'b0;
      repeat (6) step(); cap_en = 1'b0;
      for (int a = 0; a < 16; a++) exp_q.push_back({1'b1, 4'(a), 1'b0});
      for (int k = 1; k <= 5; k++) exp_q.push_back({1'b0, 4'(k), 1'b1});
      total++; if (cap_q.size() != 21) begin bad++; $display("FAIL bp_count: got %0d want 21", cap_q.size()); end
      for (int i = 0; i < 21 && i < cap_q.size(); i++) begin
         total++; if (cap_q[i] !== exp_q[i]) begin
            bad++; $display("FAIL bp_write i=%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_periodic();
      logic       eb;
      logic [3:0] ea;
      do_reset();
      for (int c = 1; c <= 50; c++) begin
         step();
         eb = (c >= 9 && c <= 24) || (c >= 33 && c <= 48);
         ea = (c <= 24) ? 4'(c - 9) : 4'(c - 33);
         total++; if (busy_p !== eb || we_p !== eb) begin
            bad++; $display("FAIL periodic_busy c=%0d: got busy=%b we=%b want %b", c, busy_p, we_p, eb); end
         if (eb) begin
            total++; if (addr_p !== ea) begin
               bad++; $display("FAIL periodic_addr c=%0d: got %0d want %0d", c, addr_p, ea); end
         end
      end
   endtask

   task automatic test_restart();
      do_reset(); clear_req = 1'b1; step(); clear_req = 1'b0;
      cap_q.delete(); cap_en = 1'b1;
      repeat (7) step();
      clear_req = 1'b1; step(); clear_req = 1'b0;
      repeat (20) step(); cap_en = 1'b0;
      total++; if (cap_q.size() != 24) begin bad++; $display("FAIL restart_count: got %0d want 24", cap_q.size()); end
      for (int i = 0; i < 24 && i < cap_q.size(); i++) begin
         total++; if (cap_q[i] !== {1'b1, (i < 8) ? 4'(i) : 4'(i - 8), 1'b0}) begin
            bad++; $display("FAIL restart_write i=%0d: got %h", i, cap_q[i]); end
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL restart_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_flush_on_start();
      do_reset(); clear_req = 1'b1; step(); clear_req = 1'b0;
      cap_q.delete(); cap_en = 1'b1;
      viol_valid = 1'b1; viol_idx = 4'd9;  viol_data = 1'b1; step();
      viol_idx = 4'd10; step();
      viol_valid = 1'b0; step(); step();
      clear_req = 1'b1; step(); clear_req = 1'b0;
      repeat (25) step(); cap_en = 1'b0;
      total++; if (cap_q.size() != 21) begin bad++; $display("FAIL flush_count: got %0d want 21", cap_q.size()); end
      for (int i = 0; i < 21 && i < cap_q.size(); i++) begin
         total++; if (cap_q[i] !== {1'b1, (i < 5) ? 4'(i) : 4'(i - 5), 1'b0}) begin
            bad++; $display("FAIL flush_write i=%0d: got %h", i, cap_q[i]); end
      end
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL flush_ready: got %b want 1", ready); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_back_to_back();
      test_backpressure();
      test_periodic();
      test_restart();
      test_flush_on_start();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
